// File: rtl/im2col_reader_pkg.sv
// rtl/im2col_reader_pkg.sv - shared convolution constants, memory map and reader state type
// Consumed by im2col, im2col_reader and the convolution top.
package im2col_reader_pkg;

  localparam int IMG_W       = 5;
  localparam int IMG_H       = 4;
  localparam int FILTER_SIZE = 3;
  localparam int FILTER_NUM  = 4;

  localparam int CONV_M = IMG_H * IMG_W;
  localparam int CONV_N = FILTER_SIZE * FILTER_SIZE;
  localparam int CONV_K = FILTER_NUM;

  localparam int WORD_W     = 32;
  localparam int MEM_ADDR_W = 32;

  localparam logic [31:0] MAP_IMG_BASE    = 32'h0000_0000;
  localparam logic [31:0] MAP_WEIGHT_BASE = 32'h0000_1000;
  localparam logic [31:0] MAP_IM2COL_BASE = 32'h0000_2000;
  localparam logic [31:0] MAP_OUTPUT_BASE = 32'h0000_3000;
  localparam logic [31:0] MAP_MEM_SIZE    = 32'h0000_4000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    DONE
  } state_e;

endpackage

// File: rtl/im2col_reader_if.sv
// rtl/im2col_reader_if.sv - memory read port plus packed-row handshake of the im2col reader
// master is the reader side; slave is the memory/consumer side.
interface im2col_reader_if import im2col_reader_pkg::*; #(
  parameter int M          = CONV_M,
  parameter int N          = CONV_N,
  parameter int DATA_WIDTH = WORD_W,
  parameter int ADDR_WIDTH = MEM_ADDR_W,
  parameter int ROW_W      = $clog2(M + 1)
) ();

  logic                    start;
  logic [DATA_WIDTH-1:0]   data_rd;
  logic [ADDR_WIDTH-1:0]   addr_rd;
  logic [DATA_WIDTH*N-1:0] X;
  logic                    x_valid;
  logic                    x_ready;
  logic [ROW_W-1:0]        row_idx;
  logic                    done;

  modport master (
    input  start, data_rd, x_ready,
    output addr_rd, X, x_valid, row_idx, done
  );

  modport slave (
    output start, data_rd, x_ready,
    input  addr_rd, X, x_valid, row_idx, done
  );

endinterface

// File: rtl/im2col_reader.sv
// rtl/im2col_reader.sv - reads M im2col rows of N words and presents each as one packed X vector
// Memory has 1-cycle read latency, so a row takes N+1 fetch cycles.
module im2col_reader import im2col_reader_pkg::*; #(
  parameter int                    M           = CONV_M,
  parameter int                    N           = CONV_N,
  parameter int                    DATA_WIDTH  = WORD_W,
  parameter int                    ADDR_WIDTH  = MEM_ADDR_W,
  parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = ADDR_WIDTH'(MAP_IM2COL_BASE),
  parameter int                    ROW_W       = $clog2(M + 1)
) (
  input logic              clk_i,
  input logic              rst_i,
  im2col_reader_if.master  bus_io
);

  localparam int COL_W = $clog2(N + 1);
  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(N);
  localparam logic [COL_W-1:0] COL_ADDR_LAST = COL_W'(N - 1);
  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(M - 1);

  state_e                           state_q, state_d;
  logic [COL_W-1:0]                 col_q, col_d;
  logic [ROW_W-1:0]                 row_q, row_d;
  logic [ADDR_WIDTH-1:0]            addr_q, addr_d;
  logic [N-1:0][DATA_WIDTH-1:0]     x_q, x_d;
  logic                             done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= IM2COL_BASE;
      x_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    x_d     = x_q;
    done_d  = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus_io.start) begin
          state_d = FETCH;
          col_d   = '0;
          row_d   = '0;
          addr_d  = IM2COL_BASE;
          done_d  = 1'b0;
        end
      end
      FETCH: begin
        // Word read at col-1 arrives now; the address stops advancing after the last word.
        if (col_q != '0) x_d[col_q - 1'b1] = bus_io.data_rd;
        if (col_q < COL_ADDR_LAST) addr_d = addr_q + 1'b1;
        if (col_q == COL_LAST) state_d = PRESENT;
        else                   col_d   = col_q + 1'b1;
      end
      PRESENT: begin
        if (bus_io.x_ready) begin
          row_d = row_q + 1'b1;
          if (row_q == ROW_LAST) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            // Rows are contiguous, so the next row starts one past the held address.
            col_d   = '0;
            addr_d  = addr_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_io.addr_rd = addr_q;
  assign bus_io.X       = x_q;
  assign bus_io.x_valid = (state_q == PRESENT);
  assign bus_io.row_idx = row_q;
  assign bus_io.done    = done_q;

endmodule

// File: tb/tb_im2col_reader.sv
// tb/tb_im2col_reader.sv - randomized self-checking bench for im2col_reader
module tb_im2col_reader;
  import im2col_reader_pkg::*;

  localparam int M  = 20;
  localparam int N  = 9;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam logic [31:0] BASE = MAP_IM2COL_BASE;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [31:0] mem [0:16383];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  im2col_reader_if #(.M(M), .N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  im2col_reader_if #(.M(1), .N(1), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) tbus ();

  im2col_reader #(.M(M), .N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IM2COL_BASE(BASE))
    dut (.clk_i(clk), .rst_i(rst), .bus_io(bus));
  im2col_reader #(.M(1), .N(1), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IM2COL_BASE(BASE))
    dut_t (.clk_i(clk), .rst_i(rst), .bus_io(tbus));

  always @(posedge clk) begin
    bus.data_rd  <= mem[bus.addr_rd[13:0]];
    tbus.data_rd <= mem[tbus.addr_rd[13:0]];
  end

  task automatic check(input string tag, input logic [287:0] act, input logic [287:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [287:0] exp_row(input int r);
    logic [287:0] v = '0;
    for (int c = 0; c < N; c++) v[c*DW +: DW] = mem[int'(BASE) + N*r + c];
    return v;
  endfunction

  task automatic pulse_start(output int t0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    t0 = cyc;
  endtask

  // mode 0: ready always high; 1: 7 stall cycles on row 3; 2: random ready
  task automatic run_pass(input int mode, input int abort_row, input bit inject,
                          output int first_valid, output int done_cyc);
    int r = 0;
    int ph = 0;
    int budget = 0;
    int stall_left = 7;
    bit pstall = 1'b0;
    logic [287:0] px = '0;
    logic [31:0] paddr = '0;
    first_valid = -1;
    done_cyc = -1;
    while (r < M && budget < 3000) begin
      check("done_low", bus.done, 0);
      check("row_idx", bus.row_idx, r);
      check("x_valid", bus.x_valid, ph > N);
      if (ph < N) check("addr_fetch", bus.addr_rd, BASE + N*r + ph);
      else        check("addr_hold", bus.addr_rd, BASE + N*r + N - 1);
      if (pstall) begin
        check("stall_x", bus.X, px);
        check("stall_addr", bus.addr_rd, paddr);
      end
      if (r == abort_row && ph == 4) return;
      if (ph > N && first_valid < 0) first_valid = cyc;
      bus.start = inject && ((r == 2 && ph == 3) || (r == 4 && ph > N));
      if (mode == 2) bus.x_ready = 1'($urandom_range(0, 1));
      else if (mode == 1 && r == 3 && ph > N && stall_left > 0) begin
        bus.x_ready = 1'b0;
        stall_left--;
      end else bus.x_ready = 1'b1;
      pstall = 1'b0;
      if (ph > N) begin
        if (bus.x_ready) begin
          check("row_data", bus.X, exp_row(r));
          r++;
          ph = 0;
        end else pstall = 1'b1;
      end else ph++;
      px = bus.X;
      paddr = bus.addr_rd;
      @(negedge clk);
      budget++;
    end
    bus.start = 1'b0;
    check("rows_done", r, M);
    done_cyc = cyc;
    check("done_set", bus.done, 1);
    check("done_row", bus.row_idx, M);
    check("done_valid", bus.x_valid, 0);
    check("done_keep_x", bus.X, exp_row(M - 1));
    @(negedge clk);
    check("done_sticky", bus.done, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, fv, dc;
    bus.start = 1'b0;
    bus.x_ready = 1'b0;
    tbus.start = 1'b0;
    tbus.x_ready = 1'b0;
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    for (int i = 0; i < M*N; i++) mem[int'(BASE) + i] = i;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.x_valid, 0);
    check("rst_row", bus.row_idx, 0);
    check("rst_addr", bus.addr_rd, BASE);
    check("rst_done", bus.done, 0);
    check("rst_x", bus.X, 0);
    check("rst_t_x", tbus.X, 0);
    rst = 1'b1;

    while (cyc < 9) @(negedge clk);
    bus.x_ready = 1'b1;
    pulse_start(t0);
    run_pass(0, -1, 1'b0, fv, dc);
    check("first_valid_cycle", fv, 20);
    check("done_cycle", dc, 230);

    pulse_start(t0);
    run_pass(1, -1, 1'b0, fv, dc);
    check("bp_done_cycle", dc - t0, M*(N+2) + 7);

    for (int i = 0; i < M*N; i++) mem[int'(BASE) + i] = $urandom;
    pulse_start(t0);
    run_pass(0, 7, 1'b0, fv, dc);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_valid", bus.x_valid, 0);
    check("midrst_row", bus.row_idx, 0);
    check("midrst_addr", bus.addr_rd, BASE);
    check("midrst_done", bus.done, 0);
    check("midrst_x", bus.X, 0);

    pulse_start(t0);
    run_pass(2, -1, 1'b1, fv, dc);
    pulse_start(t0);
    run_pass(2, -1, 1'b0, fv, dc);

    mem[int'(BASE)] = $urandom | 32'h1;
    tbus.start = 1'b1;
    @(negedge clk);
    tbus.start = 1'b0;
    check("tiny_addr_k0", tbus.addr_rd, BASE);
    check("tiny_valid_k0", tbus.x_valid, 0);
    @(negedge clk);
    check("tiny_addr_k1", tbus.addr_rd, BASE);
    check("tiny_valid_k1", tbus.x_valid, 0);
    @(negedge clk);
    check("tiny_valid", tbus.x_valid, 1);
    check("tiny_x", tbus.X, mem[int'(BASE)]);
    check("tiny_done_low", tbus.done, 0);
    tbus.x_ready = 1'b1;
    @(negedge clk);
    tbus.x_ready = 1'b0;
    check("tiny_done", tbus.done, 1);
    check("tiny_valid_drop", tbus.x_valid, 0);
    check("tiny_row", tbus.row_idx, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/im2col_reader.md
Name: im2col_reader

Overview:
- Reads the im2col matrix written to shared memory by the im2col block: M rows of N words at IM2COL_BASE.
- Packs each row into one N-word X vector and hands it to the systolic_array feed logic over a valid/ready handshake.
- This block reads what im2col writes. It replaces the bench-side preload of X_buffer.
- It drives the same single-port synchronous memory, which has 1-cycle read latency: data_rd is valid the cycle after addr_rd.

Parameters:
- M, 20, number of im2col rows (IMG_H*IMG_W).
- N, 9, words per row (FILTER_SIZE*FILTER_SIZE).
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 32, memory address width.
- IM2COL_BASE, 32'h00002000, word address of row 0, element 0.
- ROW_W, $clog2(M+1), width of the row counter.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a full M-row pass.
- data_rd  in  DATA_WIDTH  memory read data, registered in memory (1-cycle latency).
- addr_rd  out  ADDR_WIDTH  memory read word address.
- X  out  DATA_WIDTH*N  packed row; element c occupies bits [(c+1)*DATA_WIDTH-1 : c*DATA_WIDTH].
- x_valid  out  1  X holds a complete row.
- x_ready  in  1  consumer accepts X when x_valid && x_ready.
- row_idx  out  ROW_W  index of the row currently fetched/presented; equals M when finished.
- done  out  1  all M rows accepted; sticky.

Behaviour:
- Reset (rst==0 at a clk edge), applied next edge, including mid-operation:
  - state=IDLE, X=0, x_valid=0, addr_rd=IM2COL_BASE, row_idx=0, done=0, column counter=0.
  - Any in-flight read is discarded.
- States: IDLE, FETCH, PRESENT, DONE.
- IDLE:
  - start=1 -> FETCH; row_idx=0, col=0.
  - Otherwise stay in IDLE.
- FETCH: N+1 cycles per row, indexed k=0..N.
  - For k<N: addr_rd = IM2COL_BASE + N*row_idx + k.
  - For k>=1: data_rd is captured into X element k-1.
  - At k=N the last word is captured -> PRESENT.
  - addr_rd holds its last value during k=N.
  - Address arithmetic is ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH; no range check.
- PRESENT:
  - x_valid=1. X and row_idx stay stable until the handshake.
  - On x_valid && x_ready: x_valid drops the next cycle.
    - If row_idx==M-1: row_idx=M, done=1 -> DONE.
    - Else: row_idx+1, col=0 -> FETCH.
- Timing:
  - x_valid first rises N+1 cycles after the start edge (start sampled at T; X valid at T+N+1).
  - With x_ready held high: one row per N+2 cycles. A full pass is M*(N+2) cycles from start to the done edge.
- DONE:
  - done=1, x_valid=0; X keeps the last row.
  - start=1 restarts a pass: done cleared the next cycle, row_idx=0 -> FETCH.
- start while in FETCH or PRESENT is ignored; there is no restart mid-pass.
- x_ready asserted without x_valid has no effect.
- Elements of X not yet overwritten in the current FETCH keep their previous row's values. Only x_valid qualifies X.
- The block never writes memory. The integrator must keep the im2col writer idle (its done asserted) before pulsing start.

Decomposition:
- Shared package (e.g. conv_pkg):
  - State enum {IDLE, FETCH, PRESENT, DONE}.
  - Memory map constants: IMG_BASE, WEIGHT_BASE, IM2COL_BASE, OUTPUT_BASE, MEM_SIZE.
  - Derived M, N, K from IMG_W, IMG_H, FILTER_SIZE, FILTER_NUM.
  - These are shared with im2col and the top.
- No sub-module. The column/row counters, address adder and packing register stay inline in one module.

Test Plan:
- Basic pass:
  - Stimulus: defaults; mem[0x2000+i]=i for i<180; x_ready tied 1; start pulse at cycle 10.
  - Required: x_valid first at cycle 20 with X element c = c; row r element c = 9r+c; 20 rows; done rises at cycle 10+20*11=230.
- Backpressure:
  - Stimulus: x_ready low for 7 cycles during row 3.
  - Required: X stays 27..35, row_idx stays 3, addr_rd constant; the row is accepted once on the first ready cycle, with no duplicate or skipped rows.
- Address sequence:
  - Stimulus: monitor addr_rd during row 5.
  - Required: 0x202D..0x2035 on consecutive cycles; data captured one cycle later.
- Reset mid-row:
  - Stimulus: rst=0 for one cycle at FETCH k=4 of row 7.
  - Required: next cycle x_valid=0, row_idx=0, addr_rd=0x2000, done=0; a new start re-reads from row 0 correctly.
- Restart and ignored start:
  - Stimulus: start pulses during FETCH and during PRESENT; then another start in DONE.
  - Required: the first two are ignored and the pass completes normally; the DONE start clears done and reproduces identical rows.
- Tiny config:
  - Stimulus: M=1, N=1.
  - Required: addr 0x2000 read; x_valid two cycles after start; done one cycle after the handshake.
